// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add 16x16 multiplier sequencing the shared ALU; define ALU_MUL_EARLY_EXIT_EN to stop once the multiplier is exhausted
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] OP_A,
  input  logic [WIDTH-1:0] OP_B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0] ALU_LEFT,
  output logic [WIDTH-1:0] ALU_RIGHT,
  output logic             ALU_ADD,
  output logic             ALU_SHL,
  output logic             ALU_SHR,
  input  logic [WIDTH-1:0] ALU_RESULT
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, FIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic go, last;
  assign go = state_q == IDLE && START;
`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last = cnt_q == CW'(WIDTH-1) || ALU_RESULT == '0;
`else
  assign last = cnt_q == CW'(WIDTH-1);
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  always_comb begin
    state_d   = state_q == IDLE ? (START ? ADD : IDLE) :
                state_q == ADD  ? SHL :
                state_q == SHL  ? SHR :
                state_q == SHR  ? (last ? FIN : ADD) : IDLE;
    acc_d     = go ? '0 : ALU_ADD ? ALU_RESULT : acc_q;
    mcand_d   = go ? OP_A : ALU_SHL ? ALU_RESULT : mcand_q;
    mplier_d  = go ? OP_B : ALU_SHR ? ALU_RESULT : mplier_q;
    cnt_d     = go ? '0 : ALU_SHR ? cnt_q + CW'(1) : cnt_q;
    product_d = ALU_SHR && last ? acc_q : product_q;
  end
  always_comb begin
    ALU_ADD   = state_q == ADD && mplier_q[0];
    ALU_SHL   = state_q == SHL;
    ALU_SHR   = state_q == SHR;
    ALU_LEFT  = ALU_ADD ? acc_q : ALU_SHL ? mcand_q : ALU_SHR ? mplier_q : '0;
    ALU_RIGHT = ALU_ADD ? mcand_q : '0;
    BUSY      = state_q == ADD || ALU_SHL || ALU_SHR;
    DONE      = state_q == FIN;
    PRODUCT   = product_q;
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;
  logic clk = 0;
  logic rst, start, busy, done, alu_add, alu_shl, alu_shr;
  logic [15:0] op_a, op_b, product, alu_left, alu_right, alu_result;
  int n_assert = 0;
  int n_fail = 0;
  bit mon_en = 0;
  logic [15:0] sb[$];
  always #5 clk = ~clk;
  assign alu_result = alu_add ? alu_left + alu_right : alu_shl ? alu_left << 1 : alu_shr ? alu_left >> 1 : 16'h0;
  alu_mul_seq dut (
    .CLK(clk), .RST(rst), .START(start), .OP_A(op_a), .OP_B(op_b),
    .BUSY(busy), .DONE(done), .PRODUCT(product),
    .ALU_LEFT(alu_left), .ALU_RIGHT(alu_right),
    .ALU_ADD(alu_add), .ALU_SHL(alu_shl), .ALU_SHR(alu_shr),
    .ALU_RESULT(alu_result)
  );
  always @(negedge clk) begin
    if (mon_en) begin
      n_assert++;
      if ($countones({alu_add, alu_shl, alu_shr}) > 1 ||
          ({alu_add, alu_shl, alu_shr} == 3'b000 && (alu_left | alu_right) != 16'h0)) begin
        n_fail++;
        $display("FAIL strobes: add/shl/shr=%b left=%h right=%h, required one-hot and idle operands 0",
                 {alu_add, alu_shl, alu_shr}, alu_left, alu_right);
      end
      if (done) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: product=%h, required no DONE", product);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          if (product !== e) begin
            n_fail++;
            $display("FAIL product: got %h, required %h", product, e);
          end
        end
      end
    end
  end
  function automatic int exp_n(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 16;
`endif
  endfunction
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(output int cyc, output int busy_cnt, output bit add_seen);
    cyc = 0;
    busy_cnt = 0;
    add_seen = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (busy) busy_cnt++;
      if (alu_add) add_seen = 1;
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    start = 0;
    op_a = 0;
    op_b = 0;
    repeat (2) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_assert++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_assert++;
    if (product !== 16'h0) begin n_fail++; $display("FAIL reset_product: got %h, required 0000", product); end
    n_assert++;
    if ({alu_add, alu_shl, alu_shr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b, required 000", {alu_add, alu_shl, alu_shr});
    end
    n_assert++;
    if ({alu_left, alu_right} !== 32'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h/%h, required 0000/0000", alu_left, alu_right);
    end
    rst = 0;
    mon_en = 1;
  endtask
  task automatic test_fixed_latency;
    int cyc, bc;
    bit as;
    sb.push_back(16'h000F);
    issue(16'd3, 16'd5);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd5)) begin n_fail++; $display("FAIL latency_3x5: got %0d, required %0d", cyc, 3 * exp_n(16'd5)); end
    n_assert++;
    if (bc != 3 * exp_n(16'd5)) begin n_fail++; $display("FAIL busy_cycles: got %0d, required %0d", bc, 3 * exp_n(16'd5)); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_in_fin: got %b, required 0", busy); end
    @(negedge clk);
    n_assert++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b, required 0", done); end
  endtask
  task automatic test_wrap;
    logic [15:0] acc, mc, m;
    logic [34:0] got, exp;
    acc = 0;
    mc = 16'hFFFF;
    m = 16'hFFFF;
    sb.push_back(16'h0001);
    issue(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      got = {alu_add, alu_shl, alu_shr, alu_left, alu_right};
      exp = {m[0], 2'b00, m[0] ? acc : 16'h0, m[0] ? mc : 16'h0};
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_add_%0d: got %h, required %h", i, got, exp); end
      if (m[0]) acc = acc + mc;
      @(negedge clk);
      got = {alu_add, alu_shl, alu_shr, alu_left, alu_right};
      exp = {3'b010, mc, 16'h0};
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_shl_%0d: got %h, required %h", i, got, exp); end
      mc = mc << 1;
      @(negedge clk);
      got = {alu_add, alu_shl, alu_shr, alu_left, alu_right};
      exp = {3'b001, m, 16'h0};
      n_assert++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_shr_%0d: got %h, required %h", i, got, exp); end
      m = m >> 1;
      @(negedge clk);
    end
    n_assert++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b, required 1", done); end
    n_assert++;
    if (product !== 16'h0001) begin n_fail++; $display("FAIL wrap_product: got %h, required 0001", product); end
    @(negedge clk);
  endtask
  task automatic test_early_exit;
    int cyc, bc;
    bit as;
    sb.push_back(16'h0023);
    issue(16'd7, 16'd5);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd5)) begin n_fail++; $display("FAIL latency_7x5: got %0d, required %0d", cyc, 3 * exp_n(16'd5)); end
    sb.push_back(16'h0000);
    issue(16'h1234, 16'h0000);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'h0)) begin n_fail++; $display("FAIL latency_b0: got %0d, required %0d", cyc, 3 * exp_n(16'h0)); end
    n_assert++;
    if (as) begin n_fail++; $display("FAIL add_with_b0: got add asserted, required never"); end
  endtask
  task automatic test_busy_start;
    int ndone = 0;
    int first = -1;
    sb.push_back(16'h000F);
    issue(16'd3, 16'd5);
    for (int c = 0; c < 60; c++) begin
      if (c == 9) begin
        op_a = 16'd9;
        start = 1;
      end else start = 0;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
    n_assert++;
    if (ndone != 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d, required 1", ndone); end
    n_assert++;
    if (first != 3 * exp_n(16'd5)) begin n_fail++; $display("FAIL busy_start_latency: got %0d, required %0d", first, 3 * exp_n(16'd5)); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_idle: got %b, required 0", busy); end
  endtask
  task automatic test_reset_mid;
    int cyc, bc;
    bit as;
    sb.push_back(16'h0004);
    issue(16'd2, 16'd2);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd2)) begin n_fail++; $display("FAIL latency_2x2: got %0d, required %0d", cyc, 3 * exp_n(16'd2)); end
    issue(16'd3, 16'hFFFF);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_assert++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abort_busy_done: got %b, required 00", {busy, done}); end
    n_assert++;
    if ({alu_add, alu_shl, alu_shr} !== 3'b000) begin
      n_fail++; $display("FAIL abort_strobes: got %b, required 000", {alu_add, alu_shl, alu_shr});
    end
    n_assert++;
    if (product !== 16'h0) begin n_fail++; $display("FAIL abort_product: got %h, required 0000", product); end
    sb.push_back(16'h0010);
    issue(16'd4, 16'd4);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd4)) begin n_fail++; $display("FAIL latency_4x4: got %0d, required %0d", cyc, 3 * exp_n(16'd4)); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    int cyc, bc;
    bit as;
    sb.push_back(16'h0006);
    sb.push_back(16'h0006);
    @(negedge clk);
    op_a = 16'd2;
    op_b = 16'd3;
    start = 1;
    @(negedge clk);
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd3)) begin n_fail++; $display("FAIL b2b_first: got %0d, required %0d", cyc, 3 * exp_n(16'd3)); end
    @(negedge clk);
    n_assert++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gap: got %b, required 00", {busy, done}); end
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart: got %b, required 1", busy); end
    start = 0;
    wait_done(cyc, bc, as);
    n_assert++;
    if (cyc != 3 * exp_n(16'd3)) begin n_fail++; $display("FAIL b2b_second: got %0d, required %0d", cyc, 3 * exp_n(16'd3)); end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_fixed_latency();
    test_wrap();
    test_early_exit();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_assert++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
